rmap_rdfifo_mc: RTL and testbench

Parametrised multi-channel register map on the local bus (lb_*). It provides per-channel enable and flush controls, NCH read-FIFO data registers with a variable-latency read handshake, and a read timeout with sticky status and an interrupt. It sits between the bus bridge and NCH peripheral RX FIFOs.

---
 rtl/rmap_rdfifo_mc.sv | 194 +++++++++++++++++++
 tb/tb_rmap_rdfifo_mc.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rmap_rdfifo_mc.sv
// -----------------------------------------------------------------------------
// rmap_rdfifo_mc
//   Multi-channel local-bus register map in front of NCH peripheral RX FIFOs.
//   Provides per-channel enable and flush controls, one read-data register per
//   FIFO with a variable-latency pop handshake, and a read timeout that sets a
//   sticky per-channel status bit and can raise an interrupt.
//
//   Register map (byte addresses):
//     0x00       CTRL     EN[NCH-1:0] rw, FLUSH[8+NCH-1:8] wo self-clearing
//     0x04       STATUS   TOUT[NCH-1:0] rw1c sticky, IRQ_EN[8+NCH-1:8] rw
//     0x10+4*i   RDFIFO_i DATA[FIFO_DW-1:0], VALID at bit DATA_W-1
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ch_en_out       per-channel enable (CTRL.EN)
//   ch_flush_out    one-cycle flush pulse per channel
//   fifo_ren        one-cycle pop request to channel i (combinational)
//   fifo_rdata      packed FIFO data, channel i at [i*FIFO_DW +: FIFO_DW]
//   fifo_rvalid     fifo_rdata valid for channel i
//   irq             registered OR of (STATUS.TOUT & STATUS.IRQ_EN)
//   lb_w*           write channel, always ready, completes in one cycle
//   lb_raddr/ren    read request; master waits for lb_rvalid before the next
//   lb_rdata/rvalid read data and one-cycle completion pulse
// -----------------------------------------------------------------------------
module rmap_rdfifo_mc #(
  parameter int          ADDR_W  = 8,
  parameter int          DATA_W  = 16,
  parameter int          STRB_W  = DATA_W / 8,
  parameter int          NCH     = 4,
  parameter int          FIFO_DW = 12,
  parameter int          TIMEOUT = 16,
  parameter logic [15:0] ERR_VAL = 16'hdead
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [NCH-1:0]         ch_en_out,
  output logic [NCH-1:0]         ch_flush_out,
  output logic [NCH-1:0]         fifo_ren,
  input  logic [NCH*FIFO_DW-1:0] fifo_rdata,
  input  logic [NCH-1:0]         fifo_rvalid,
  output logic                   irq,
  input  logic [ADDR_W-1:0]      lb_waddr,
  input  logic [DATA_W-1:0]      lb_wdata,
  input  logic                   lb_wen,
  input  logic [STRB_W-1:0]      lb_wstrb,
  output logic                   lb_wready,
  input  logic [ADDR_W-1:0]      lb_raddr,
  input  logic                   lb_ren,
  output logic [DATA_W-1:0]      lb_rdata,
  output logic                   lb_rvalid
);

  localparam int                CH_W     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int                CNT_W    = 8;
  localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_VAL);

  typedef enum logic { S_IDLE, S_WAIT } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CH_W-1:0]    cur_ch;

  logic [NCH-1:0]     en, flush, tout, irq_en;
  logic [NCH-1:0]     tout_set, tout_clr;
  logic               wr_ctrl, wr_stat;

  logic               rd_fifo;
  logic [CH_W-1:0]    rd_ch;
  logic [DATA_W-1:0]  reg_rdata;
  logic [DATA_W-1:0]  data_word;
  logic [FIFO_DW-1:0] cur_data;
  logic               start;
  logic               timeout_hit;

  assign lb_wready    = 1'b1;
  assign ch_en_out    = en;
  assign ch_flush_out = flush;

  // ---------------------------------------------------------------------------
  // Write decode and control/status registers
  // ---------------------------------------------------------------------------
  assign wr_ctrl  = lb_wen && (lb_waddr == ADDR_W'(0));
  assign wr_stat  = lb_wen && (lb_waddr == ADDR_W'(4));
  assign tout_clr = (wr_stat && lb_wstrb[0]) ? lb_wdata[NCH-1:0] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      en     <= '0;
      flush  <= '0;
      tout   <= '0;
      irq_en <= '0;
      irq    <= 1'b0;
    end else begin
      flush <= '0;
      if (wr_ctrl && lb_wstrb[0]) en     <= lb_wdata[NCH-1:0];
      if (wr_ctrl && lb_wstrb[1]) flush  <= lb_wdata[8 +: NCH];
      if (wr_stat && lb_wstrb[1]) irq_en <= lb_wdata[8 +: NCH];
      // Set is OR-ed in after the clear so a timeout beats a same-cycle rw1c.
      tout <= (tout & ~tout_clr) | tout_set;
      irq  <= |(tout & irq_en);
    end
  end

  // ---------------------------------------------------------------------------
  // Read decode
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no latch is inferred
  // on paths that do not assign it.
  always_comb begin
    rd_fifo = 1'b0;
    rd_ch   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (lb_raddr == ADDR_W'(16 + 4 * i)) begin
        rd_fifo = 1'b1;
        rd_ch   = CH_W'(i);
      end
    end
  end

  // Immediate-response data; also covers unmapped and disabled-channel reads.
  always_comb begin
    reg_rdata = ERR_WORD;
    if (lb_raddr == ADDR_W'(0)) begin
      reg_rdata            = '0;
      reg_rdata[NCH-1:0]   = en;
    end else if (lb_raddr == ADDR_W'(4)) begin
      reg_rdata            = '0;
      reg_rdata[NCH-1:0]   = tout;
      reg_rdata[8 +: NCH]  = irq_en;
    end
  end

  assign start    = !rst && (state == S_IDLE) && lb_ren && rd_fifo && en[rd_ch];
  assign fifo_ren = start ? (NCH'(1) << rd_ch) : '0;

  assign cur_data = fifo_rdata[int'(cur_ch) * FIFO_DW +: FIFO_DW];

  always_comb begin
    data_word                = '0;
    data_word[DATA_W-1]      = 1'b1;
    data_word[FIFO_DW-1:0]   = cur_data;
  end

  // Data arriving in the final counted cycle takes priority over the timeout.
  assign timeout_hit = (state == S_WAIT) && !fifo_rvalid[cur_ch] &&
                       (cnt == CNT_W'(TIMEOUT));
  assign tout_set    = timeout_hit ? (NCH'(1) << cur_ch) : '0;

  // ---------------------------------------------------------------------------
  // Read FSM with registered bus response
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cur_ch    <= '0;
      lb_rvalid <= 1'b0;
      lb_rdata  <= ERR_WORD;
    end else begin
      lb_rvalid <= 1'b0;
      lb_rdata  <= ERR_WORD;
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_WAIT;
            cnt    <= CNT_W'(1);
            cur_ch <= rd_ch;
          end else if (lb_ren) begin
            lb_rvalid <= 1'b1;
            lb_rdata  <= reg_rdata;
          end
        end
        S_WAIT: begin
          // lb_ren is deliberately ignored here; the master is still waiting.
          if (fifo_rvalid[cur_ch]) begin
            lb_rvalid <= 1'b1;
            lb_rdata  <= data_word;
            state     <= S_IDLE;
          end else if (timeout_hit) begin
            lb_rvalid <= 1'b1;
            lb_rdata  <= '0;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rmap_rdfifo_mc.sv
// -----------------------------------------------------------------------------
// tb_rmap_rdfifo_mc
//   Directed self-checking bench for rmap_rdfifo_mc with default parameters
//   (NCH=4, FIFO_DW=12, TIMEOUT=16, DATA_W=16). Inputs change 2 time units
//   after the rising edge; outputs are sampled there or 1 unit later.
// -----------------------------------------------------------------------------
module tb_rmap_rdfifo_mc;

  logic        clk;
  logic        rst;
  logic [3:0]  ch_en_out, ch_flush_out, fifo_ren, fifo_rvalid;
  logic [47:0] fifo_rdata;
  logic        irq;
  logic [7:0]  lb_waddr, lb_raddr;
  logic [15:0] lb_wdata, lb_rdata;
  logic        lb_wen, lb_wready, lb_ren, lb_rvalid;
  logic [1:0]  lb_wstrb;

  int nvec = 0;
  int nerr = 0;
  int ren_pulses = 0;

  rmap_rdfifo_mc dut (
    .clk          (clk),
    .rst          (rst),
    .ch_en_out    (ch_en_out),
    .ch_flush_out (ch_flush_out),
    .fifo_ren     (fifo_ren),
    .fifo_rdata   (fifo_rdata),
    .fifo_rvalid  (fifo_rvalid),
    .irq          (irq),
    .lb_waddr     (lb_waddr),
    .lb_wdata     (lb_wdata),
    .lb_wen       (lb_wen),
    .lb_wstrb     (lb_wstrb),
    .lb_wready    (lb_wready),
    .lb_raddr     (lb_raddr),
    .lb_ren       (lb_ren),
    .lb_rdata     (lb_rdata),
    .lb_rvalid    (lb_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every fifo_ren pop pulse the DUT issues.
  always @(posedge clk) ren_pulses += $countones(fifo_ren);

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] s);
    lb_waddr = a;
    lb_wdata = d;
    lb_wstrb = s;
    lb_wen   = 1'b1;
    tick();
    lb_wen   = 1'b0;
  endtask

  // Immediate-response read: data expected in T+1 with no FIFO pop.
  task automatic rd_reg(input string tag, input logic [7:0] a, input logic [15:0] exp);
    int n0 = ren_pulses;
    lb_raddr = a;
    lb_ren   = 1'b1;
    tick();
    lb_ren   = 1'b0;
    check({tag, " rvalid"}, lb_rvalid, 1);
    check({tag, " rdata"}, lb_rdata, exp);
    check({tag, " no pop"}, ren_pulses - n0, 0);
  endtask

  // Starts a FIFO read in the current cycle T and checks the pop pattern.
  task automatic rd_start(input string tag, input logic [7:0] a, input logic [3:0] exp_ren);
    lb_raddr = a;
    lb_ren   = 1'b1;
    #1;
    check({tag, " fifo_ren"}, fifo_ren, exp_ren);
    tick();
    lb_ren   = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    check({tag, " ch_en_out"}, ch_en_out, 4'b0000);
    check({tag, " ch_flush_out"}, ch_flush_out, 4'b0000);
    check({tag, " fifo_ren"}, fifo_ren, 4'b0000);
    check({tag, " irq"}, irq, 1'b0);
    check({tag, " lb_rvalid"}, lb_rvalid, 1'b0);
    check({tag, " lb_rdata"}, lb_rdata, 16'hdead);
  endtask

  initial begin
    int k;
    logic any;

    rst         = 1'b1;
    lb_waddr    = '0;
    lb_wdata    = '0;
    lb_wen      = 1'b0;
    lb_wstrb    = '0;
    lb_raddr    = '0;
    lb_ren      = 1'b0;
    fifo_rvalid = '0;
    fifo_rdata  = '0;

    // Reset state
    repeat (3) tick();
    chk_reset_outputs("reset");
    check("wready", lb_wready, 1'b1);
    rst = 1'b0;
    tick();

    // CTRL write with both strobes: EN=0101, flush pulse 1111 for one cycle
    wr(8'h00, 16'h0f05, 2'b11);
    check("ctrl en", ch_en_out, 4'b0101);
    check("ctrl flush pulse", ch_flush_out, 4'b1111);
    tick();
    check("ctrl flush clear", ch_flush_out, 4'b0000);
    rd_reg("rd ctrl", 8'h00, 16'h0005);

    // CTRL write with only the upper strobe: EN untouched, FLUSH byte is 0
    wr(8'h00, 16'h0003, 2'b10);
    check("strb en kept", ch_en_out, 4'b0101);
    check("strb no flush", ch_flush_out, 4'b0000);

    // RDFIFO_2 read, data 3 cycles after pop; lb_ren during WAIT and
    // fifo_rvalid on another channel are ignored
    k = ren_pulses;
    rd_start("fifo2", 8'h18, 4'b0100);             // now T+1
    lb_ren = 1'b1;
    #1;
    check("wait ren ignored T+1", fifo_ren, 4'b0000);
    tick();                                          // T+2
    check("wait ren ignored T+2", fifo_ren, 4'b0000);
    fifo_rvalid = 4'b0001;
    tick();                                          // T+3
    lb_ren      = 1'b0;
    check("other ch rvalid ignored", lb_rvalid, 1'b0);
    fifo_rvalid = 4'b0100;
    fifo_rdata[2*12 +: 12] = 12'habc;
    tick();                                          // T+4
    fifo_rvalid = 4'b0000;
    check("fifo2 rvalid", lb_rvalid, 1'b1);
    check("fifo2 rdata", lb_rdata, 16'h8abc);
    check("fifo2 single pop", ren_pulses - k, 1);
    tick();                                          // T+5
    check("fifo2 rvalid drop", lb_rvalid, 1'b0);
    check("fifo2 rdata idle", lb_rdata, 16'hdead);

    // Timeout on channel 1 with interrupt enabled
    wr(8'h00, 16'h0002, 2'b01);
    wr(8'h04, 16'h0200, 2'b10);
    rd_start("tout1", 8'h14, 4'b0010);              // now T+1
    k = 1;
    while (!lb_rvalid && k < 64) begin
      tick();
      k++;
    end
    check("tout1 latency", k, 17);
    check("tout1 rdata", lb_rdata, 16'h0000);
    check("tout1 irq not yet", irq, 1'b0);
    tick();
    check("tout1 irq", irq, 1'b1);
    fifo_rvalid = 4'b0010;                           // late data after timeout
    tick();
    fifo_rvalid = 4'b0000;
    check("late rvalid ignored", lb_rvalid, 1'b0);
    rd_reg("rd status tout", 8'h04, 16'h0202);

    // rw1c clear of TOUT; IRQ_EN kept, irq drops one cycle after STATUS
    wr(8'h04, 16'h0202, 2'b11);
    check("irq still high", irq, 1'b1);
    rd_reg("rd status clr", 8'h04, 16'h0200);
    check("irq dropped", irq, 1'b0);

    // Disabled channel and unmapped address
    rd_reg("rd fifo0 disabled", 8'h10, 16'hdead);
    rd_reg("rd unmapped", 8'h3c, 16'hdead);

    // Timeout set and rw1c clear of the same bit in one cycle: set wins
    rd_start("setwin", 8'h14, 4'b0010);              // now T+1
    repeat (14) tick();                              // T+15
    check("setwin no rvalid", lb_rvalid, 1'b0);
    tick();                                          // T+16
    lb_waddr = 8'h04;
    lb_wdata = 16'h0002;
    lb_wstrb = 2'b01;
    lb_wen   = 1'b1;
    tick();                                          // T+17
    lb_wen   = 1'b0;
    check("setwin rvalid", lb_rvalid, 1'b1);
    check("setwin rdata", lb_rdata, 16'h0000);
    rd_reg("rd status setwin", 8'h04, 16'h0202);
    wr(8'h04, 16'h0002, 2'b01);

    // fifo_rvalid in the final counted cycle wins over timeout; EN cleared
    // during WAIT does not abort the read
    wr(8'h00, 16'h000e, 2'b01);
    rd_start("race", 8'h18, 4'b0100);                // now T+1
    lb_waddr = 8'h00;
    lb_wdata = 16'h0000;
    lb_wstrb = 2'b01;
    lb_wen   = 1'b1;
    tick();                                          // T+2
    lb_wen   = 1'b0;
    check("race en cleared", ch_en_out, 4'b0000);
    repeat (14) tick();                              // T+16
    check("race no early rvalid", lb_rvalid, 1'b0);
    fifo_rvalid = 4'b0100;
    fifo_rdata[2*12 +: 12] = 12'h123;
    tick();                                          // T+17
    fifo_rvalid = 4'b0000;
    check("race rvalid", lb_rvalid, 1'b1);
    check("race rdata", lb_rdata, 16'h8123);
    rd_reg("rd status race", 8'h04, 16'h0200);

    // Reset during WAIT on channel 3
    wr(8'h00, 16'h0008, 2'b01);
    rd_start("rstwait", 8'h1c, 4'b1000);             // now T+1
    tick();                                          // T+2
    rst = 1'b1;
    tick();                                          // T+3
    rst = 1'b0;
    chk_reset_outputs("rst mid-wait");
    fifo_rvalid = 4'b1000;
    fifo_rdata[3*12 +: 12] = 12'h777;
    any = 1'b0;
    repeat (20) begin
      tick();
      any |= lb_rvalid;
    end
    fifo_rvalid = 4'b0000;
    check("rst no rvalid", any, 1'b0);
    rd_reg("rd ctrl after rst", 8'h00, 16'h0000);
    rd_reg("rd status after rst", 8'h04, 16'h0000);

    check("total pops", ren_pulses, 5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
